// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result stage.
package hilo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_MUL,
      ST_NEG_LO,
      ST_NEG_HI,
      ST_COMMIT
   } hilo_state_t;

   typedef enum logic [1:0] {
      MOVE_NONE = 2'b00,
      MOVE_HI   = 2'b01,
      MOVE_LO   = 2'b10,
      MOVE_RSVD = 2'b11
   } move_op_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 48;

endpackage

// File: rtl/hilo_negate32.sv
// One 32-bit slice of a two's-complement negation: Sum = ~Operand + CarryIn.
module hilo_negate32 (
   input  logic [31:0] Operand,
   input  logic        CarryIn,
   output logic [31:0] Sum,
   output logic        CarryOut
);

   assign {CarryOut, Sum} = {1'b0, ~Operand} + {32'd0, CarryIn};

endmodule

// File: rtl/hilo_unit.sv
// HI/LO result stage: sign-corrects the multiplier product and commits it to HI/LO.
// Optional watchdog on the multiplier wait enabled by defining HILO_TIMEOUT_EN.
module hilo_unit
   import hilo_pkg::*;
`ifdef HILO_TIMEOUT_EN
   #(parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES)
`endif
   (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MulStart,
   input  logic        MulSigned,
   input  logic        SignA,
   input  logic        SignB,
   input  logic [63:0] Product,
   input  logic        EndMulFlag,
   input  logic [1:0]  MoveOp,
   input  logic [31:0] WriteData,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic        Busy,
   output logic        MulDone
`ifdef HILO_TIMEOUT_EN
   ,
   output logic        MulTimeout
`endif
   );

   hilo_state_t state;
   logic        neg;
   logic [63:0] word;
   logic        carry;
   logic        flag_s;
   logic        flag_p;
   logic        flag_rise;
   logic [31:0] neg_in;
   logic        neg_cin;
   logic [31:0] neg_sum;
   logic        neg_cout;

`ifdef HILO_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   // Both tracker bits start high on MulStart, so a level left over from the
   // previous multiply never looks like a rising edge.
   assign flag_rise = flag_s & ~flag_p;

   // NOTE: every signal assigned in always_comb gets a default first; a path
   // that skips an assignment would otherwise infer a latch.
   always_comb begin
      neg_in  = word[31:0];
      neg_cin = 1'b1;
      if (state == ST_NEG_HI) begin
         neg_in  = word[63:32];
         neg_cin = carry;
      end
   end

   hilo_negate32 u_negate (
      .Operand  (neg_in),
      .CarryIn  (neg_cin),
      .Sum      (neg_sum),
      .CarryOut (neg_cout)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         neg     <= 1'b0;
         word    <= '0;
         carry   <= 1'b0;
         flag_s  <= 1'b0;
         flag_p  <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
         Busy    <= 1'b0;
         MulDone <= 1'b0;
`ifdef HILO_TIMEOUT_EN
         wait_cnt   <= '0;
         MulTimeout <= 1'b0;
`endif
      end else begin
         MulDone <= 1'b0;
`ifdef HILO_TIMEOUT_EN
         MulTimeout <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (MulStart) begin
                  neg    <= MulSigned & (SignA ^ SignB);
                  flag_s <= 1'b1;
                  flag_p <= 1'b1;
                  Busy   <= 1'b1;
                  state  <= ST_WAIT_MUL;
`ifdef HILO_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  case (MoveOp)
                     MOVE_HI:   Hi <= WriteData;
                     MOVE_LO:   Lo <= WriteData;
                     MOVE_NONE: ;
                     default:   ;
                  endcase
               end
            end
            ST_WAIT_MUL: begin
               flag_s <= EndMulFlag;
               flag_p <= flag_s;
               if (flag_rise) begin
                  word  <= Product;
                  state <= neg ? ST_NEG_LO : ST_COMMIT;
               end
`ifdef HILO_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  Busy       <= 1'b0;
                  MulTimeout <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            ST_NEG_LO: begin
               word[31:0] <= neg_sum;
               carry      <= neg_cout;
               state      <= ST_NEG_HI;
            end
            ST_NEG_HI: begin
               word[63:32] <= neg_sum;
               state       <= ST_COMMIT;
            end
            ST_COMMIT: begin
               Hi      <= word[63:32];
               Lo      <= word[31:0];
               MulDone <= 1'b1;
               Busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; covers the timeout path when
// HILO_TIMEOUT_EN is defined.
module tb_hilo_unit;
   import hilo_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MulStart;
   logic        MulSigned;
   logic        SignA;
   logic        SignB;
   logic [63:0] Product;
   logic        EndMulFlag;
   logic [1:0]  MoveOp;
   logic [31:0] WriteData;
   logic [31:0] Hi;
   logic [31:0] Lo;
   logic        Busy;
   logic        MulDone;
`ifdef HILO_TIMEOUT_EN
   logic        MulTimeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hilo_unit dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .MulStart   (MulStart),
      .MulSigned  (MulSigned),
      .SignA      (SignA),
      .SignB      (SignB),
      .Product    (Product),
      .EndMulFlag (EndMulFlag),
      .MoveOp     (MoveOp),
      .WriteData  (WriteData),
      .Hi         (Hi),
      .Lo         (Lo),
      .Busy       (Busy),
      .MulDone    (MulDone)
`ifdef HILO_TIMEOUT_EN
      ,
      .MulTimeout (MulTimeout)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_mul(input logic sgn, input logic sa, input logic sb,
                            input logic [63:0] prod, input logic keep_flag);
      MulStart  = 1'b1;
      MulSigned = sgn;
      SignA     = sa;
      SignB     = sb;
      Product   = prod;
      if (!keep_flag) EndMulFlag = 1'b0;
      step();
      MulStart = 1'b0;
      check("busy_after_start", Busy, 1'b1);
   endtask

   // Drop the done flag for one sampled cycle, then raise it; returns just after edge E.
   task automatic raise_flag();
      EndMulFlag = 1'b0;
      step();
      EndMulFlag = 1'b1;
      step();
   endtask

   task automatic expect_done(input string tag, input int lat,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      for (int i = 1; i <= lat; i++) begin
         step();
         if (i < lat) begin
            check({tag, "_early_done"}, MulDone, 1'b0);
         end else begin
            check({tag, "_done"}, MulDone, 1'b1);
            check({tag, "_busy"}, Busy, 1'b0);
            check({tag, "_hi"}, Hi, exp_hi);
            check({tag, "_lo"}, Lo, exp_lo);
         end
      end
      step();
      check({tag, "_pulse_end"}, MulDone, 1'b0);
   endtask

   task automatic move(input logic [1:0] op, input logic [31:0] data);
      MoveOp    = op;
      WriteData = data;
      step();
      MoveOp    = MOVE_NONE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset      = 1'b1;
      MulStart   = 1'b0;
      MulSigned  = 1'b0;
      SignA      = 1'b0;
      SignB      = 1'b0;
      Product    = '0;
      EndMulFlag = 1'b0;
      MoveOp     = MOVE_NONE;
      WriteData  = '0;
      step();
      step();
      Reset = 1'b0;
      check("rst_hi", Hi, 32'h0);
      check("rst_lo", Lo, 32'h0);
      check("rst_busy", Busy, 1'b0);
      check("rst_muldone", MulDone, 1'b0);
`ifdef HILO_TIMEOUT_EN
      check("rst_timeout", MulTimeout, 1'b0);
`endif

      start_mul(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
      raise_flag();
      expect_done("multu_big", 2, 32'hFFFF_FFFE, 32'h0000_0001);

      start_mul(1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
      raise_flag();
      expect_done("mult_neg15", 4, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      start_mul(1'b1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b0);
      raise_flag();
      expect_done("mult_neg_carry", 4, 32'hFFFF_FFFF, 32'h0000_0000);

      start_mul(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      raise_flag();
      expect_done("mult_neg_zero", 4, 32'h0, 32'h0);

      start_mul(1'b1, 1'b1, 1'b1, 64'h0000_0002_0000_0003, 1'b0);
      raise_flag();
      expect_done("mult_pos", 2, 32'h0000_0002, 32'h0000_0003);

      start_mul(1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
      raise_flag();
      expect_done("multu_signs", 2, 32'h8000_0000, 32'h0000_0000);

      // Stale flag still high from the previous multiply; MTHI while busy is ignored.
      start_mul(1'b0, 1'b0, 1'b0, 64'h1111_1111_2222_2222, 1'b1);
      move(MOVE_HI, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stale_no_done", MulDone, 1'b0);
      end
      check("stale_busy", Busy, 1'b1);
      check("mthi_busy_hi", Hi, 32'h8000_0000);
      raise_flag();
      expect_done("stale_then_rise", 2, 32'h1111_1111, 32'h2222_2222);

      move(MOVE_LO, 32'h1234_5678);
      check("mtlo_lo", Lo, 32'h1234_5678);
      check("mtlo_hi", Hi, 32'h1111_1111);
      check("mtlo_nodone", MulDone, 1'b0);
      move(MOVE_HI, 32'hCAFE_F00D);
      check("mthi_hi", Hi, 32'hCAFE_F00D);
      check("mthi_lo", Lo, 32'h1234_5678);
      move(MOVE_RSVD, 32'h5555_5555);
      check("rsvd_hi", Hi, 32'hCAFE_F00D);
      check("rsvd_lo", Lo, 32'h1234_5678);

      // MulStart and MTHI in the same cycle: the move is dropped.
      MoveOp    = MOVE_HI;
      WriteData = 32'h0000_0BAD;
      start_mul(1'b0, 1'b0, 1'b0, 64'h0000_0003_0000_0004, 1'b0);
      MoveOp = MOVE_NONE;
      check("start_wins_hi", Hi, 32'hCAFE_F00D);
      raise_flag();
      expect_done("start_wins_mul", 2, 32'h0000_0003, 32'h0000_0004);

      // Reset while in NEG_HI discards the in-flight multiply immediately.
      start_mul(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0005, 1'b0);
      raise_flag();
      step();
      step();
      check("pre_rst_busy", Busy, 1'b1);
      Reset = 1'b1;
      #1;
      check("mid_rst_hi", Hi, 32'h0);
      check("mid_rst_lo", Lo, 32'h0);
      check("mid_rst_busy", Busy, 1'b0);
      check("mid_rst_done", MulDone, 1'b0);
      step();
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_no_done", MulDone, 1'b0);
      end
      check("post_rst_hi", Hi, 32'h0);
      move(MOVE_LO, 32'h0000_00A5);
      check("post_rst_idle_mtlo", Lo, 32'h0000_00A5);

`ifdef HILO_TIMEOUT_EN
      start_mul(1'b0, 1'b0, 1'b0, 64'h7777_7777_7777_7777, 1'b0);
      for (int i = 1; i <= 48; i++) begin
         step();
         if (i < 48) begin
            check("to_early", MulTimeout, 1'b0);
         end else begin
            check("to_pulse", MulTimeout, 1'b1);
            check("to_busy", Busy, 1'b0);
            check("to_nodone", MulDone, 1'b0);
            check("to_hi", Hi, 32'h0);
            check("to_lo", Lo, 32'h0000_00A5);
         end
      end
      step();
      check("to_pulse_end", MulTimeout, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Result stage directly downstream of the shift-add multiplier. Consumes the raw unsigned 64-bit magnitude product and the multiplier's done flag, applies two's-complement sign correction for signed MULT, and commits the result into the architectural HI/LO registers. Also services MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO, with a busy interlock toward the control FSM.

## Interface
- TIMEOUT_CYCLES, 48: watchdog limit in WAIT_MUL (used only with the macro below).
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MulStart  in  1  one-cycle pulse from control when a MULT/MULTU is issued.
- MulSigned  in  1  sampled with MulStart; 1 = MULT, 0 = MULTU.
- SignA, SignB  in  1 each  operand sign bits, sampled with MulStart.
- Product  in  64  raw unsigned magnitude product from the multiplier.
- EndMulFlag  in  1  multiplier done flag (level; stays high until the next MULT).
- MoveOp  in  2  00 none, 01 MTHI, 10 MTLO, 11 reserved (no-op).
- WriteData  in  32  data for MTHI/MTLO.
- Hi, Lo  out  32 each  architectural HI/LO; reset 0.
- Busy  out  1  high from the cycle after MulStart until commit; reset 0.
- MulDone  out  1  one-cycle pulse, coincident with the first cycle new Hi/Lo are visible; reset 0.

## Operation
- States: IDLE, WAIT_MUL, NEG_LO, NEG_HI, COMMIT.
- IDLE: MulStart -> latch Neg = MulSigned & (SignA ^ SignB), clear edge tracker, go WAIT_MUL. MoveOp handled only in IDLE without MulStart; MulStart wins if both occur in the same cycle (MoveOp dropped).
- WAIT_MUL: accept only a 0->1 transition of EndMulFlag sampled inside WAIT_MUL (stale high level from a previous multiply is ignored). On accept, capture Product into internal 64-bit register; Neg=0 -> COMMIT, Neg=1 -> NEG_LO.
- NEG_LO: low word <= ~P[31:0] + 1; store carry-out.
- NEG_HI: high word <= ~P[63:32] + carry.
- COMMIT: Hi <= word[63:32], Lo <= word[31:0], MulDone pulses next cycle, return to IDLE.
- Arithmetic: 64-bit wrap-around; negating zero gives zero (carry propagates into high word).
- In any non-IDLE state: MulStart and MoveOp ignored, EndMulFlag outside WAIT_MUL ignored, Hi/Lo hold.
- Reset at any time: state IDLE, Hi=Lo=0, Busy=0, MulDone=0, internal registers cleared; an in-flight multiply is discarded.

## Timing
- MulStart sampled at edge T -> Busy high from T+1.
- EndMulFlag rising sampled at edge E: unsigned/non-negative -> Hi/Lo and MulDone visible after edge E+2; negative -> after edge E+4.
- Busy falls in the same cycle MulDone rises.
- MTHI/MTLO sampled at edge W -> new Hi/Lo visible after W; no MulDone.

## Configuration
- HILO_TIMEOUT_EN defined: cycle counter runs in WAIT_MUL; on reaching TIMEOUT_CYCLES without accepted EndMulFlag, return to IDLE, Hi/Lo unchanged, no MulDone, extra output port MulTimeout (1 bit, one-cycle pulse, reset 0).
- Undefined: no counter, no MulTimeout port; WAIT_MUL waits indefinitely.

## Structure
- hilo_pkg: state enum, MoveOp encodings (MOVE_NONE, MOVE_HI, MOVE_LO), default timeout constant.
- One sub-module: hilo_negate32 (32-bit invert plus carry-in, outputs sum and carry-out), instantiated once and reused by NEG_LO and NEG_HI.

## Test plan
- MULTU, Product 0xFFFFFFFE_00000001, EndMulFlag rise -> Hi=0xFFFFFFFE, Lo=0x00000001, MulDone 2 cycles after rise.
- MULT SignA=1 SignB=0, Product 0x0000000F -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, MulDone 4 cycles after rise.
- MULT negative, Product 0x00000001_00000000 -> Hi=0xFFFFFFFF, Lo=0x00000000 (carry into high word); negative with Product 0 -> Hi=Lo=0.
- EndMulFlag held high from previous op when MulStart arrives -> no commit until it drops and rises again.
- MTLO 0x12345678 in IDLE -> Lo=0x12345678 next cycle; MTHI during Busy -> Hi unchanged.
- Reset asserted in NEG_HI -> Hi=Lo=0, Busy=0, state IDLE immediately; with HILO_TIMEOUT_EN, no EndMulFlag for 48 cycles -> MulTimeout pulse, Hi/Lo unchanged.
